// File: rtl/wb_stage_if.sv
// Memory-stage -> writeback bus, plus the register-file write / bypass triples.
//   master : memory stage / register file / bypass network side
//   slave  : wb_stage
// Signals:
//   in_valid, in_ready, flush, stall          capture handshake and kill/hold controls
//   pc, inst, alu_result, ctrl_reg_we, wb_sel  retiring instruction payload
//   mem_rdata                                 raw DMEM word, valid the cycle after capture
//   reg_we, reg_wa, data_rd                   register-file write triple
//   fwd_valid, fwd_rd, fwd_data               bypass copy of the write triple
interface wb_stage_if #(
   parameter int unsigned DWIDTH     = 32,
   parameter int unsigned PC_WIDTH   = 32,
   parameter int unsigned INST_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  flush;
   logic                  stall;
   logic [PC_WIDTH-1:0]   pc;
   logic [INST_WIDTH-1:0] inst;
   logic [DWIDTH-1:0]     alu_result;
   logic                  ctrl_reg_we;
   logic [1:0]            wb_sel;
   logic [DWIDTH-1:0]     mem_rdata;

   logic                  reg_we;
   logic [4:0]            reg_wa;
   logic [DWIDTH-1:0]     data_rd;
   logic                  fwd_valid;
   logic [4:0]            fwd_rd;
   logic [DWIDTH-1:0]     fwd_data;

   modport master (
      output in_valid, flush, stall, pc, inst, alu_result, ctrl_reg_we, wb_sel, mem_rdata,
      input  in_ready, reg_we, reg_wa, data_rd, fwd_valid, fwd_rd, fwd_data
   );

   modport slave (
      input  in_valid, flush, stall, pc, inst, alu_result, ctrl_reg_we, wb_sel, mem_rdata,
      output in_ready, reg_we, reg_wa, data_rd, fwd_valid, fwd_rd, fwd_data
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage of the 32-bit RISC-V pipeline.
// Captures one retiring instruction per cycle, selects ALU / aligned load / PC+4
// as writeback data and drives the register-file write triple for exactly one
// cycle (the cycle after capture). Also provides a bypass copy of that triple and
// a sticky misaligned-load flag.
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-low reset
//   bus           wb_stage_if.slave (capture handshake, payload, write/bypass triples)
//   misalign_err  sticky misaligned-load flag, cleared only by reset
//   instret       64-bit retired-instruction counter (only with WB_INSTRET_EN)
// Optional feature macro: WB_INSTRET_EN adds the instret counter and port.
module wb_stage #(
   parameter int unsigned DWIDTH     = 32,
   parameter int unsigned PC_WIDTH   = 32,
   parameter int unsigned INST_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   wb_stage_if.slave   bus,
   output logic        misalign_err
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0] instret
`endif
);

   localparam int unsigned RD_W  = 5;
   localparam int unsigned F3_W  = 3;
   localparam int unsigned SEL_W = 2;

   localparam logic [SEL_W-1:0] WB_MEM = 2'd1;
   localparam logic [SEL_W-1:0] WB_PC4 = 2'd2;

   localparam logic [F3_W-1:0] F3_LB  = 3'd0;
   localparam logic [F3_W-1:0] F3_LH  = 3'd1;
   localparam logic [F3_W-1:0] F3_LW  = 3'd2;
   localparam logic [F3_W-1:0] F3_LBU = 3'd4;
   localparam logic [F3_W-1:0] F3_LHU = 3'd5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      PEND  = 2'd1,
      HELD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [RD_W-1:0]     rd;
      logic [F3_W-1:0]     funct3;
      logic [DWIDTH-1:0]   alu;
      logic                we;
      logic [SEL_W-1:0]    sel;
   } cap_t;

   state_t              state;
   state_t              state_nxt;
   cap_t                cap;
   logic                capture;
   logic                misaligned;
   logic                reg_we_c;
   logic [1:0]          byte_off;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [DWIDTH-1:0]   ld_data;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic [DWIDTH-1:0]   wb_data;

   // Opcode and upper instruction fields are not needed at writeback.
   logic unused_inst;
   assign unused_inst = ^{bus.inst[INST_WIDTH-1:15], bus.inst[6:0]};

   assign bus.in_ready = ~bus.stall;
   assign capture      = bus.in_valid & ~bus.stall;

   // Capture register for the retiring instruction.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cap <= '0;
      end else if (capture) begin
         cap.pc     <= bus.pc;
         cap.rd     <= bus.inst[11:7];
         cap.funct3 <= bus.inst[14:12];
         cap.alu    <= bus.alu_result;
         cap.we     <= bus.ctrl_reg_we;
         cap.sel    <= bus.wb_sel;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and write enable; only a PEND entry may write, so HELD cannot repeat it.
   always_comb begin
      state_nxt = state;
      reg_we_c  = 1'b0;
      if (capture) begin
         state_nxt = PEND;
      end else begin
         case (state)
            PEND, HELD: state_nxt = bus.stall ? HELD : EMPTY;
            default:    state_nxt = EMPTY;
         endcase
      end
      if (state == PEND) begin
         reg_we_c = cap.we & (cap.rd != 5'd0) & ~bus.flush & ~misaligned;
      end
   end

   // Little-endian lane selection from the raw DMEM word.
   always_comb begin
      byte_off = cap.alu[1:0];
      ld_byte  = 8'h00;
      case (byte_off)
         2'd0:    ld_byte = bus.mem_rdata[7:0];
         2'd1:    ld_byte = bus.mem_rdata[15:8];
         2'd2:    ld_byte = bus.mem_rdata[23:16];
         default: ld_byte = bus.mem_rdata[31:24];
      endcase
      ld_half = byte_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (cap.funct3)
         F3_LB:   ld_data = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
         F3_LBU:  ld_data = {{(DWIDTH-8){1'b0}}, ld_byte};
         F3_LH:   ld_data = {{(DWIDTH-16){ld_half[15]}}, ld_half};
         F3_LHU:  ld_data = {{(DWIDTH-16){1'b0}}, ld_half};
         default: ld_data = bus.mem_rdata;
      endcase
   end

   // Half loads need an even address, word loads a word-aligned one.
   always_comb begin
      misaligned = 1'b0;
      if (cap.sel == WB_MEM) begin
         if ((cap.funct3 == F3_LH) || (cap.funct3 == F3_LHU)) begin
            misaligned = byte_off[0];
         end else if (cap.funct3 == F3_LW) begin
            misaligned = (byte_off != 2'd0);
         end
      end
   end

   // Writeback source mux; PC+4 wraps naturally at the PC width.
   always_comb begin
      pc_plus4 = cap.pc + PC_WIDTH'(4);
      case (cap.sel)
         WB_MEM:  wb_data = ld_data;
         WB_PC4:  wb_data = DWIDTH'(pc_plus4);
         default: wb_data = cap.alu;
      endcase
   end

   assign bus.reg_we    = reg_we_c;
   assign bus.reg_wa    = cap.rd;
   assign bus.data_rd   = wb_data;
   assign bus.fwd_valid = reg_we_c;
   assign bus.fwd_rd    = cap.rd;
   assign bus.fwd_data  = wb_data;

   // Sticky misaligned-load flag; a flushed entry never sets it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         misalign_err <= 1'b0;
      end else if ((state == PEND) && misaligned && !bus.flush) begin
         misalign_err <= 1'b1;
      end
   end

`ifdef WB_INSTRET_EN
   // Every unflushed PEND entry retires, whether or not it writes a register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         instret <= 64'd0;
      end else if ((state == PEND) && !bus.flush) begin
         instret <= instret + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_wb_stage;

   logic clk = 1'b0;
   logic rst;
   logic misalign_err;
`ifdef WB_INSTRET_EN
   logic [63:0] instret;
   longint unsigned ir_exp;
`endif

   always #5 clk = ~clk;

   wb_stage_if #(.DWIDTH(32), .PC_WIDTH(32), .INST_WIDTH(32)) bus ();

   wb_stage #(.DWIDTH(32), .PC_WIDTH(32), .INST_WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .misalign_err (misalign_err)
`ifdef WB_INSTRET_EN
      ,
      .instret      (instret)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic        we;
      logic [1:0]  sel;
      logic [31:0] mem;
      logic        exp_we;
      logic [31:0] exp_data;
   } vec_t;

   localparam int NV = 15;
   vec_t tv [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic st, input logic fl,
                        input logic [31:0] p, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] alu, input logic we, input logic [1:0] sel,
                        input logic [31:0] mem);
      bus.in_valid    = v;
      bus.stall       = st;
      bus.flush       = fl;
      bus.pc          = p;
      bus.inst        = {17'h0, f3, rd, 7'h03};
      bus.alu_result  = alu;
      bus.ctrl_reg_we = we;
      bus.wb_sel      = sel;
      bus.mem_rdata   = mem;
   endtask

   task automatic idle(input logic fl, input logic [31:0] mem);
      drive(1'b0, 1'b0, fl, 32'h0, 5'd0, 3'd0, 32'h0, 1'b0, 2'd0, mem);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string name, input logic we, input logic [4:0] wa,
                         input logic [31:0] d);
      chk({name, "_we"}, 64'(bus.reg_we), 64'(we));
      chk({name, "_wa"}, 64'(bus.reg_wa), 64'(wa));
      chk({name, "_fwd_valid"}, 64'(bus.fwd_valid), 64'(we));
      chk({name, "_fwd_rd"}, 64'(bus.fwd_rd), 64'(wa));
      if (we) begin
         chk({name, "_data"}, 64'(bus.data_rd), 64'(d));
         chk({name, "_fwd_data"}, 64'(bus.fwd_data), 64'(d));
      end
   endtask

   task automatic chk_ir(input string name);
`ifdef WB_INSTRET_EN
      chk(name, instret, ir_exp);
`else
      if (name.len() < 0) $display("%s", name);
`endif
   endtask

   function automatic logic [31:0] ref_data(input logic [31:0] pc, input logic [2:0] f3,
                                            input logic [31:0] alu, input logic [1:0] sel,
                                            input logic [31:0] mem);
      int unsigned b, h;
      b = (mem >> (8 * alu[1:0])) & 32'hFF;
      h = (mem >> (16 * alu[1])) & 32'hFFFF;
      if (sel == 2'd2) return pc + 32'd4;
      if (sel != 2'd1) return alu;
      case (f3)
         3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         3'd5:    return h;
         default: return mem;
      endcase
   endfunction

   function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] alu,
                                    input logic [1:0] sel);
      if (sel != 2'd1) return 1'b0;
      if ((f3 == 3'd1 || f3 == 3'd5) && (alu % 2 != 0)) return 1'b1;
      if (f3 == 3'd2 && (alu % 4 != 0)) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      // pc, rd, f3, alu, we, sel, mem, exp_we, exp_data
      tv[0]  = '{32'h0,        5'd5,  3'd0, 32'h1234_5678, 1'b1, 2'd0, 32'h0,         1'b1, 32'h1234_5678};
      tv[1]  = '{32'h0,        5'd6,  3'd0, 32'h0000_0103, 1'b1, 2'd1, 32'h80FF_7F01, 1'b1, 32'hFFFF_FF80};
      tv[2]  = '{32'h0,        5'd7,  3'd4, 32'h0000_0102, 1'b1, 2'd1, 32'h80FF_7F01, 1'b1, 32'h0000_00FF};
      tv[3]  = '{32'h0,        5'd8,  3'd5, 32'h0000_0102, 1'b1, 2'd1, 32'h80FF_7F01, 1'b1, 32'h0000_80FF};
      tv[4]  = '{32'h0,        5'd9,  3'd1, 32'h0000_0100, 1'b1, 2'd1, 32'h80FF_7F01, 1'b1, 32'h0000_7F01};
      tv[5]  = '{32'h0,        5'd10, 3'd1, 32'h0000_0102, 1'b1, 2'd1, 32'h80FF_7F01, 1'b1, 32'hFFFF_80FF};
      tv[6]  = '{32'h0,        5'd11, 3'd0, 32'h0000_0101, 1'b1, 2'd1, 32'h80FF_7F01, 1'b1, 32'h0000_007F};
      tv[7]  = '{32'h0,        5'd12, 3'd0, 32'h0000_0102, 1'b1, 2'd1, 32'h80FF_7F01, 1'b1, 32'hFFFF_FFFF};
      tv[8]  = '{32'h0,        5'd13, 3'd2, 32'h0000_0100, 1'b1, 2'd1, 32'h80FF_7F01, 1'b1, 32'h80FF_7F01};
      tv[9]  = '{32'h0000_1000, 5'd1, 3'd0, 32'h0,         1'b1, 2'd2, 32'h0,         1'b1, 32'h0000_1004};
      tv[10] = '{32'hFFFF_FFFC, 5'd1, 3'd0, 32'h0,         1'b1, 2'd2, 32'h0,         1'b1, 32'h0000_0000};
      tv[11] = '{32'h0,        5'd0,  3'd0, 32'hDEAD_BEEF, 1'b1, 2'd0, 32'h0,         1'b0, 32'hDEAD_BEEF};
      tv[12] = '{32'h0,        5'd14, 3'd0, 32'hCAFE_F00D, 1'b0, 2'd0, 32'h0,         1'b0, 32'hCAFE_F00D};
      tv[13] = '{32'h0,        5'd15, 3'd0, 32'h0BAD_CAFE, 1'b1, 2'd3, 32'h0,         1'b1, 32'h0BAD_CAFE};
      tv[14] = '{32'h0,        5'd16, 3'd3, 32'h0000_0101, 1'b1, 2'd1, 32'h1357_9BDF, 1'b1, 32'h1357_9BDF};

      // Reset
      rst = 1'b0;
      idle(1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
`ifdef WB_INSTRET_EN
      ir_exp = 0;
`endif
      @(negedge clk);
      chk("rst_we", 64'(bus.reg_we), 64'(1'b0));
      chk("rst_fwd_valid", 64'(bus.fwd_valid), 64'(1'b0));
      chk("rst_wa", 64'(bus.reg_wa), 64'(5'd0));
      chk("rst_misalign", 64'(misalign_err), 64'(1'b0));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
      chk_ir("rst_instret");
      tick();

      // Vector table: capture, then check the write in the following cycle
      for (int i = 0; i < NV; i++) begin
         drive(1'b1, 1'b0, 1'b0, tv[i].pc, tv[i].rd, tv[i].f3, tv[i].alu, tv[i].we, tv[i].sel, 32'h0);
         tick();
         idle(1'b0, tv[i].mem);
         @(negedge clk);
         chk_wr($sformatf("tv%0d", i), tv[i].exp_we, tv[i].rd, tv[i].exp_data);
         chk($sformatf("tv%0d_misalign", i), 64'(misalign_err), 64'(1'b0));
         tick();
`ifdef WB_INSTRET_EN
         ir_exp++;
`endif
      end
      chk_ir("tv_instret");

      // Stall in PEND: one write, then HELD until stall drops
      drive(1'b1, 1'b0, 1'b0, 32'h0, 5'd9, 3'd0, 32'h0000_A5A5, 1'b1, 2'd0, 32'h0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 3'd0, 32'h0, 1'b0, 2'd0, 32'h0);
      @(negedge clk);
      chk_wr("stall_pend", 1'b1, 5'd9, 32'h0000_A5A5);
      chk("stall_in_ready", 64'(bus.in_ready), 64'(1'b0));
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 5'd10, 3'd0, 32'h0000_BEEF, 1'b1, 2'd0, 32'h0);
      @(negedge clk);
      chk_wr("stall_held1", 1'b0, 5'd9, 32'h0);
      chk("stall_held_in_ready", 64'(bus.in_ready), 64'(1'b0));
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 5'd10, 3'd0, 32'h0000_BEEF, 1'b1, 2'd0, 32'h0);
      @(negedge clk);
      chk_wr("stall_release", 1'b0, 5'd9, 32'h0);
      chk("release_in_ready", 64'(bus.in_ready), 64'(1'b1));
      tick();
      idle(1'b0, 32'h0);
      @(negedge clk);
      chk_wr("after_release", 1'b1, 5'd10, 32'h0000_BEEF);
      tick();
`ifdef WB_INSTRET_EN
      ir_exp += 2;
`endif

      // Flush in PEND: no write, no retire
      drive(1'b1, 1'b0, 1'b0, 32'h0, 5'd3, 3'd0, 32'h0000_0033, 1'b1, 2'd0, 32'h0);
      tick();
      idle(1'b1, 32'h0);
      @(negedge clk);
      chk_wr("flush", 1'b0, 5'd3, 32'h0);
      tick();
      idle(1'b0, 32'h0);
      @(negedge clk);
      chk_wr("flush_after", 1'b0, 5'd3, 32'h0);
      chk_ir("flush_instret");
      tick();

      // Flush with simultaneous capture: old entry dies, new one writes
      drive(1'b1, 1'b0, 1'b0, 32'h0, 5'd11, 3'd0, 32'h0000_0011, 1'b1, 2'd0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 32'h0, 5'd12, 3'd0, 32'h0000_0012, 1'b1, 2'd0, 32'h0);
      @(negedge clk);
      chk_wr("flushcap_old", 1'b0, 5'd11, 32'h0);
      tick();
      idle(1'b0, 32'h0);
      @(negedge clk);
      chk_wr("flushcap_new", 1'b1, 5'd12, 32'h0000_0012);
      tick();
`ifdef WB_INSTRET_EN
      ir_exp++;
      chk_ir("flushcap_instret");
`endif

      // Reset during PEND: write still visible that cycle, cleared after the edge
      drive(1'b1, 1'b0, 1'b0, 32'h0, 5'd13, 3'd0, 32'h0000_0013, 1'b1, 2'd0, 32'h0);
      tick();
      idle(1'b0, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk_wr("rst_pend", 1'b1, 5'd13, 32'h0000_0013);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk_wr("rst_after", 1'b0, 5'd0, 32'h0);
      chk("rst_after_data", 64'(bus.data_rd), 64'(32'h0));
`ifdef WB_INSTRET_EN
      ir_exp = 0;
`endif
      chk_ir("rst_mid_instret");
      tick();

      // Misaligned LH flushed: flag stays clear
      drive(1'b1, 1'b0, 1'b0, 32'h0, 5'd15, 3'd1, 32'h0000_0101, 1'b1, 2'd1, 32'h0);
      tick();
      idle(1'b1, 32'h80FF_7F01);
      @(negedge clk);
      chk_wr("mis_flush", 1'b0, 5'd15, 32'h0);
      tick();
      idle(1'b0, 32'h0);
      @(negedge clk);
      chk("mis_flush_flag", 64'(misalign_err), 64'(1'b0));
      tick();

      // Misaligned LW: no write, sticky flag from the next cycle
      drive(1'b1, 1'b0, 1'b0, 32'h0, 5'd14, 3'd2, 32'h0000_0101, 1'b1, 2'd1, 32'h0);
      tick();
      idle(1'b0, 32'h80FF_7F01);
      @(negedge clk);
      chk_wr("mis_lw", 1'b0, 5'd14, 32'h0);
      chk("mis_lw_flag_pend", 64'(misalign_err), 64'(1'b0));
      tick();
`ifdef WB_INSTRET_EN
      ir_exp++;
`endif
      idle(1'b0, 32'h0);
      @(negedge clk);
      chk("mis_lw_flag_set", 64'(misalign_err), 64'(1'b1));
      chk_ir("mis_instret");
      tick();
      @(negedge clk);
      chk("mis_lw_flag_sticky", 64'(misalign_err), 64'(1'b1));
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("mis_flag_rst", 64'(misalign_err), 64'(1'b0));
      tick();

      // Randomized run against the behavioural model
      begin
         logic        have_prev = 1'b0;
         logic [31:0] p_pc = 0, p_alu = 0;
         logic [4:0]  p_rd = 0, last_rd = 0;
         logic [2:0]  p_f3 = 0;
         logic [1:0]  p_sel = 0;
         logic        p_we = 0;
         logic        mis_model = 1'b0;
         longint unsigned ir_model = 0;
         for (int c = 0; c < 600; c++) begin
            logic v, st, fl, we, mis, exp_we;
            logic [31:0] p, alu, mem;
            logic [4:0] rd;
            logic [2:0] f3;
            logic [1:0] sel;
            v   = ($urandom_range(3) != 0);
            st  = ($urandom_range(4) == 0);
            fl  = ($urandom_range(5) == 0);
            p   = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
            rd  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            f3  = 3'($urandom);
            alu = $urandom;
            we  = ($urandom_range(5) != 0);
            sel = 2'($urandom);
            mem = $urandom;
            drive(v, st, fl, p, rd, f3, alu, we, sel, mem);
            mis    = have_prev && ref_mis(p_f3, p_alu, p_sel);
            exp_we = have_prev && p_we && (p_rd != 0) && !fl && !mis;
            @(negedge clk);
            chk_wr($sformatf("rnd%0d", c), exp_we, last_rd,
                   ref_data(p_pc, p_f3, p_alu, p_sel, mem));
            chk($sformatf("rnd%0d_in_ready", c), 64'(bus.in_ready), 64'(!st));
            chk($sformatf("rnd%0d_misalign", c), 64'(misalign_err), 64'(mis_model));
`ifdef WB_INSTRET_EN
            chk($sformatf("rnd%0d_instret", c), instret, ir_model);
`endif
            tick();
            if (mis && !fl) mis_model = 1'b1;
            if (have_prev && !fl) ir_model++;
            have_prev = v && !st;
            if (have_prev) begin
               p_pc = p; p_rd = rd; p_f3 = f3; p_alu = alu; p_sel = sel; p_we = we;
               last_rd = rd;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 32-bit RISC-V pipeline, and the write side of the register-file port that the decode stage reads.
- Latches one retiring instruction per cycle from the memory stage and selects the writeback source: ALU result, aligned/extended load data, or PC+4.
- Drives the register-file write triple (we, waddr, wdata) for exactly one cycle per instruction.
- Also exports a forwarding copy of that triple and a sticky misaligned-load flag.

Parameters:
DWIDTH, 32, data/register width
PC_WIDTH, 32, program-counter width
INST_WIDTH, 32, instruction width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
in_valid  in  1  memory stage presents an instruction
in_ready  out  1  stage can accept this cycle
flush  in  1  kill the entry captured last cycle (no register write)
stall  in  1  downstream hold; blocks new capture
pc  in  PC_WIDTH  PC of incoming instruction
inst  in  INST_WIDTH  incoming instruction; rd=[11:7], funct3=[14:12]
alu_result  in  DWIDTH  ALU result / load byte address
ctrl_reg_we  in  1  instruction writes rd
wb_sel  in  2  0=ALU, 1=MEM, 2=PC+4, 3=ALU
mem_rdata  in  DWIDTH  raw DMEM word; valid the cycle after capture
reg_we  out  1  register-file write enable
reg_wa  out  5  register-file write address
data_rd  out  DWIDTH  register-file write data
fwd_valid  out  1  reg_we copy for the bypass network
fwd_rd  out  5  reg_wa copy
fwd_data  out  DWIDTH  data_rd copy
misalign_err  out  1  sticky misaligned-load flag

Behaviour:
- Capture register fields: pc, rd, funct3, alu_result, reg_we bit, wb_sel. State: EMPTY, PEND, HELD.
- in_ready = !stall. Capture occurs when in_valid && in_ready.
- State transitions:
  - Capture: next state PEND, regardless of current state.
  - PEND, no capture: stall=1 -> HELD; otherwise -> EMPTY.
  - HELD: stays until the next capture or until stall=0 (-> EMPTY).
- Writeback:
  - reg_we is combinational and asserted only in PEND, when the captured reg_we bit = 1, rd != 0, flush = 0, and the load is not misaligned.
  - The register file writes at the end of that cycle, so latency from capture edge to write edge is 1 cycle.
  - HELD never writes, so each instruction writes at most once.
- reg_wa = captured rd.
- data_rd source by captured wb_sel:
  - ALU: captured alu_result.
  - PC+4: captured pc + 4, modulo 2^PC_WIDTH (0xFFFFFFFC -> 0x00000000).
  - MEM: built from mem_rdata in the PEND cycle. With a = captured alu_result[1:0]:
    - funct3 0 (LB): byte a, sign-extended.
    - funct3 4 (LBU): byte a, zero-extended.
    - funct3 1 (LH): half a[1], sign-extended.
    - funct3 5 (LHU): half a[1], zero-extended.
    - funct3 2 (LW): full word.
    - Other funct3: full word.
    - Little-endian byte lanes.
- Misaligned load: wb_sel=MEM with (LH/LHU and a[0]=1) or (LW and a != 0).
  - Write is suppressed.
  - misalign_err is set at the end of that PEND cycle (unless flush) and stays set until reset.
- fwd_valid, fwd_rd and fwd_data equal reg_we, reg_wa and data_rd in the same cycle.
- Flush in a cycle where capture also occurs: the old PEND entry is killed and the new entry is captured normally.
- Reset (rst=0 on an edge), including mid-operation:
  - State -> EMPTY; all captured fields -> 0; misalign_err -> 0.
  - reg_we, fwd_valid = 0 in the following cycle.
  - An entry in PEND at that edge still completes its write (reset takes effect at the edge).
- Outputs while in EMPTY or HELD: reg_we = 0, reg_wa = captured rd, data_rd = mux value (don't-care to the register file).

Optional Feature:
WB_INSTRET_EN
- Defined: adds output instret (64 bits).
  - Counts instructions that completed PEND without flush, including those with reg_we = 0 or rd = 0.
  - A misaligned load also counts.
  - Reset value 0; wraps at 2^64.
- Not defined: no instret port and no counter logic.

Test Plan:
- ALU writeback: capture alu_result=0x12345678, rd=5, reg_we=1, wb_sel=0 -> next cycle reg_we=1, reg_wa=5, data_rd=0x12345678, fwd_valid=1.
- LB sign: mem_rdata=0x80FF7F01, alu_result=0x103, funct3=0 -> data_rd=0xFFFFFF80. Same word with LBU, addr 0x102 -> 0x000000FF. LHU, addr 0x102 -> 0x000080FF.
- Misaligned LW at addr 0x101 -> reg_we=0 and misalign_err=1 from the next cycle. Assert rst=0 for one edge -> misalign_err=0.
- JAL: pc=0x0000_1000, wb_sel=2, rd=1 -> data_rd=0x00001004. pc=0xFFFFFFFC -> data_rd=0x00000000.
- rd=0 with reg_we=1 -> reg_we stays 0. Flush asserted in the PEND cycle -> no write. With WB_INSTRET_EN, instret does not increment on the flushed entry.
- Stall in the PEND cycle -> exactly one reg_we pulse, in_ready=0 while stall=1, state HELD. Release stall with in_valid=1 -> next capture proceeds and writes one cycle later.
